// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI initiator: FSM state encoding and
// the 24-bit frame layout {opcode, register address, data}.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_FLUSH = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SETUP = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HOLD  = 3'd4,
        ST_TRAIL = 3'd5,
        ST_DONE  = 3'd6
    } spi_src_state_t;

    localparam int         SPI_FRAME_BITS   = 24;
    localparam int         SPI_ADDR_BITS    = 16;
    localparam logic [3:0] OPC_BASE_DEFAULT = 4'b0100;
    localparam logic       RW_READ          = 1'b1;

    // Reads send a zero data byte so the responder sees a clean dummy byte.
    function automatic logic [SPI_FRAME_BITS-1:0] spi_frame(
        input logic [3:0] opc,
        input logic [2:0] hw,
        input logic       rw,
        input logic [7:0] regb,
        input logic [7:0] wdata
    );
        logic [SPI_ADDR_BITS-1:0] hdr;
        hdr = {opc, hw, rw, regb};
        return {hdr, (rw == RW_READ) ? 8'h00 : wdata};
    endfunction

endpackage

// File: rtl/spi_sclk_tick.sv
// Half-period strobe generator: counts 0..CLK_DIV-1 while enabled and
// emits a registered one-cycle tick on the terminal count.
module spi_sclk_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic en_i,
    output logic tick_o
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          en_q;
    logic          tick_q;

    // en_q delays counting by one cycle so the first half-period starts
    // after the FSM has settled in its enabled state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            en_q   <= 1'b0;
            tick_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q  <= '0;
            en_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            en_q   <= 1'b1;
            tick_q <= en_q && (cnt_q == LAST);
            if (en_q) cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/spi_src.sv
// SPI mode-0 initiator: one 24-bit frame per command (opcode, register,
// data), with trailing csn-high sclk pulses to flush the responder.
module spi_src
    import spi_pkg::*;
#(
    parameter int         CLK_DIV    = 2,
    parameter int         TRAIL_CLKS = 1,
    parameter logic [3:0] OPC_BASE   = OPC_BASE_DEFAULT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [2:0] cmd_hw_addr,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       sclk_o,
    output logic       csn_o,
    output logic       mosi_o,
    input  logic       miso_i
);
    localparam logic [2:0] TRAIL_LAST = 3'(TRAIL_CLKS - 1);
    localparam logic [4:0] LAST_BIT   = 5'(SPI_FRAME_BITS);
    localparam logic [4:0] RX_FIRST   = 5'(SPI_FRAME_BITS - 8);

    spi_src_state_t            state_q, state_d;
    logic [SPI_FRAME_BITS-1:0] shreg_q, frame;
    logic [4:0]                bitcnt_q;
    logic [2:0]                trcnt_q;
    logic                      sclk_q, csn_q, mosi_q, rw_q;
    logic [7:0]                rdata_q, rsp_rdata_q;
    logic                      tick, tick_en, rise, fall, trail_done, accept;

    spi_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rstn   (rstn),
        .en_i   (tick_en),
        .tick_o (tick)
    );

    assign frame      = spi_frame(OPC_BASE, cmd_hw_addr, cmd_rw, cmd_reg, cmd_wdata);
    assign rise       = tick && !sclk_q;
    assign fall       = tick && sclk_q;
    assign accept     = cmd_valid && (state_q == ST_IDLE);
    assign trail_done = (TRAIL_CLKS == 0) || (fall && trcnt_q == TRAIL_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_FLUSH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FLUSH: if (trail_done) state_d = ST_IDLE;
            ST_IDLE:  if (cmd_valid) state_d = ST_SETUP;
            ST_SETUP: if (tick) state_d = ST_SHIFT;
            ST_SHIFT: if (fall && bitcnt_q == LAST_BIT) state_d = ST_HOLD;
            ST_HOLD:  if (tick) state_d = (TRAIL_CLKS == 0) ? ST_DONE : ST_TRAIL;
            ST_TRAIL: if (trail_done) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_FLUSH;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        rsp_valid = (state_q == ST_DONE);
        tick_en   = (state_q == ST_FLUSH) || (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                    (state_q == ST_HOLD)  || (state_q == ST_TRAIL);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            trcnt_q     <= '0;
            sclk_q      <= 1'b0;
            csn_q       <= 1'b1;
            mosi_q      <= 1'b0;
            rw_q        <= 1'b0;
            rdata_q     <= '0;
            rsp_rdata_q <= '0;
        end else begin
            // Response byte is published as DONE is entered so it lines up with rsp_valid.
            if (state_d == ST_DONE && state_q != ST_DONE)
                rsp_rdata_q <= (rw_q == RW_READ) ? rdata_q : 8'h00;
            case (state_q)
                ST_IDLE: if (accept) begin
                    shreg_q  <= frame;
                    rw_q     <= cmd_rw;
                    bitcnt_q <= '0;
                    trcnt_q  <= '0;
                    rdata_q  <= '0;
                    csn_q    <= 1'b0;
                    mosi_q   <= frame[SPI_FRAME_BITS-1];
                end
                ST_FLUSH, ST_TRAIL: if (tick) begin
                    sclk_q <= ~sclk_q;
                    if (sclk_q) trcnt_q <= trcnt_q + 3'd1;
                end
                ST_SHIFT: if (rise) begin
                    sclk_q <= 1'b1;
                    if (bitcnt_q != LAST_BIT) bitcnt_q <= bitcnt_q + 5'd1;
                    if (rw_q == RW_READ && bitcnt_q >= RX_FIRST) rdata_q <= {rdata_q[6:0], miso_i};
                end else if (fall) begin
                    sclk_q <= 1'b0;
                    if (bitcnt_q != LAST_BIT) begin
                        shreg_q <= {shreg_q[SPI_FRAME_BITS-2:0], 1'b0};
                        mosi_q  <= shreg_q[SPI_FRAME_BITS-2];
                    end
                end
                ST_HOLD: if (tick) begin
                    csn_q  <= 1'b1;
                    mosi_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign sclk_o    = sclk_q;
    assign csn_o     = csn_q;
    assign mosi_o    = mosi_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_src.sv
// Bench for spi_src: two instances (default and CLK_DIV=3/TRAIL_CLKS=2) against
// a behavioural responder that records MOSI and serves a chosen read byte on MISO.
module tb_spi_src;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn[2];
    logic       cmd_valid[2], cmd_rw[2], cmd_ready[2], rsp_valid[2], busy[2];
    logic [2:0] cmd_hw_addr[2];
    logic [7:0] cmd_reg[2], cmd_wdata[2], rsp_rdata[2];
    logic       sclk[2], csn[2], mosi[2], miso[2];

    spi_src #(.CLK_DIV(2), .TRAIL_CLKS(1)) u_dut0 (
        .clk(clk), .rstn(rstn[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_rw(cmd_rw[0]), .cmd_hw_addr(cmd_hw_addr[0]), .cmd_reg(cmd_reg[0]),
        .cmd_wdata(cmd_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .busy(busy[0]), .sclk_o(sclk[0]), .csn_o(csn[0]), .mosi_o(mosi[0]), .miso_i(miso[0])
    );

    spi_src #(.CLK_DIV(3), .TRAIL_CLKS(2)) u_dut1 (
        .clk(clk), .rstn(rstn[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_rw(cmd_rw[1]), .cmd_hw_addr(cmd_hw_addr[1]), .cmd_reg(cmd_reg[1]),
        .cmd_wdata(cmd_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .busy(busy[1]), .sclk_o(sclk[1]), .csn_o(csn[1]), .mosi_o(mosi[1]), .miso_i(miso[1])
    );

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc;
    logic [23:0] mon_frame[2];
    int          mon_bits[2], mon_trail[2], mon_rise1[2], mon_period[2], mon_rsp[2];
    logic [7:0]  rbyte[2];
    logic        p_sclk[2], p_csn[2];

    function automatic int div_of(input int u);   return (u == 0) ? 2 : 3; endfunction
    function automatic int trail_of(input int u); return (u == 0) ? 1 : 2; endfunction
    function automatic int lat_of(input int u);   return div_of(u) * (50 + 2 * trail_of(u)) + 2; endfunction

    function automatic logic [23:0] model_frame(input logic rw, input logic [2:0] hw,
                                                input logic [7:0] rg, input logic [7:0] wd);
        logic [7:0] opc;
        opc = 8'h40 + 8'(hw) * 8'd2 + 8'(rw);
        return {opc, rg, rw ? 8'h00 : wd};
    endfunction

    // Responder / pin monitor, evaluated just after every rising clk edge.
    initial begin
        cyc = 0;
        for (int u = 0; u < 2; u++) begin
            mon_frame[u] = '0; mon_bits[u] = 0; mon_trail[u] = 0;
            mon_rise1[u] = 0;  mon_period[u] = 0; mon_rsp[u] = 0;
            p_sclk[u] = 1'b0;  p_csn[u] = 1'b1; miso[u] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int u = 0; u < 2; u++) begin
                if (p_csn[u] && !csn[u]) begin
                    mon_frame[u] = '0; mon_bits[u] = 0; mon_trail[u] = 0;
                end
                if (sclk[u] && !p_sclk[u]) begin
                    if (!csn[u]) begin
                        mon_frame[u] = {mon_frame[u][22:0], mosi[u]};
                        mon_bits[u]++;
                        if (mon_bits[u] == 1) mon_rise1[u] = cyc;
                        else if (mon_bits[u] == 2) mon_period[u] = cyc - mon_rise1[u];
                    end else begin
                        mon_trail[u]++;
                    end
                end
                if (rsp_valid[u]) mon_rsp[u]++;
                if (!csn[u] && mon_bits[u] >= 16 && mon_bits[u] < 24)
                    miso[u] = rbyte[u][7 - (mon_bits[u] - 16)];
                else
                    miso[u] = 1'($urandom_range(0, 1));
                p_sclk[u] = sclk[u];
                p_csn[u]  = csn[u];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int u, input logic rw, input logic [2:0] hw,
                         input logic [7:0] rg, input logic [7:0] wd);
        cmd_rw[u] = rw; cmd_hw_addr[u] = hw; cmd_reg[u] = rg; cmd_wdata[u] = wd;
    endtask

    task automatic drive_rand(input int u);
        drive(u, 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic wait_ready(input int u, output int acc);
        acc = -1;
        for (int i = 0; i < 1000; i++) begin
            if (cmd_ready[u]) begin acc = cyc + 1; break; end
            @(negedge clk);
        end
        if (acc < 0) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input int u, output int rc);
        rc = -1;
        for (int i = 0; i < 3000; i++) begin
            if (rsp_valid[u]) begin rc = cyc; break; end
            @(negedge clk);
        end
        if (rc < 0) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_rsp(input int u, input int acc, input int rc,
                             input logic [23:0] ef, input logic [7:0] ed);
        chk("latency",    32'(rc - acc),     32'(lat_of(u)));
        chk("rsp_rdata",  32'(rsp_rdata[u]), 32'(ed));
        chk("mosi_frame", 32'(mon_frame[u]), 32'(ef));
        chk("frame_bits", 32'(mon_bits[u]),  32'd24);
        chk("trail_clks", 32'(mon_trail[u]), 32'(trail_of(u)));
        chk("sclk_period",32'(mon_period[u]),32'(2 * div_of(u)));
    endtask

    // One command: accept, then keep cmd_valid high with scrambled fields while busy.
    task automatic run_cmd(input int u, input logic rw, input logic [2:0] hw,
                           input logic [7:0] rg, input logic [7:0] wd, input logic [7:0] rb);
        int acc, rc;
        rbyte[u] = rb;
        @(negedge clk);
        drive(u, rw, hw, rg, wd);
        cmd_valid[u] = 1'b1;
        wait_ready(u, acc);
        chk("idle_trail", 32'(mon_trail[u]), 32'(trail_of(u)));
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            drive_rand(u);
            if (k == 15) begin
                chk("busy_while_frame", 32'(busy[u]), 32'd1);
                chk("ready_while_frame", 32'(cmd_ready[u]), 32'd0);
            end
        end
        cmd_valid[u] = 1'b0;
        wait_rsp(u, rc);
        if (rc >= 0) check_rsp(u, acc, rc, model_frame(rw, hw, rg, wd), rw ? rb : 8'h00);
        @(negedge clk);
        chk("rsp_one_cycle", 32'(rsp_valid[u]), 32'd0);
        chk("ready_after",   32'(cmd_ready[u]), 32'd1);
        chk("rdata_held",    32'(rsp_rdata[u]), 32'(rw ? rb : 8'h00));
    endtask

    initial begin
        int acc1, acc2, rc1, rc2, r0;
        logic       rw;
        logic [7:0] rb;
        for (int u = 0; u < 2; u++) begin
            rstn[u] = 1'b1; cmd_valid[u] = 1'b0; rbyte[u] = 8'h00;
            drive(u, 1'b0, 3'd0, 8'h00, 8'h00);
        end
        #2;
        rstn[0] = 1'b0; rstn[1] = 1'b0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_csn",   32'(csn[u]),       32'd1);
            chk("rst_sclk",  32'(sclk[u]),      32'd0);
            chk("rst_mosi",  32'(mosi[u]),      32'd0);
            chk("rst_rsp",   32'(rsp_valid[u]), 32'd0);
            chk("rst_rdata", 32'(rsp_rdata[u]), 32'd0);
            chk("rst_ready", 32'(cmd_ready[u]), 32'd0);
            chk("rst_busy",  32'(busy[u]),      32'd1);
        end
        rstn[0] = 1'b1; rstn[1] = 1'b1;

        // Directed write and read on the default instance
        run_cmd(0, 1'b0, 3'd0, 8'h0A, 8'h5A, 8'hF0);
        run_cmd(0, 1'b1, 3'd0, 8'h12, 8'h77, 8'hF0);

        // Back-to-back read then write with cmd_valid held high
        rbyte[0] = 8'hF0;
        @(negedge clk);
        drive(0, 1'b1, 3'd0, 8'h12, 8'h00);
        cmd_valid[0] = 1'b1;
        wait_ready(0, acc1);
        @(negedge clk);
        drive(0, 1'b0, 3'd5, 8'h34, 8'hA5);
        wait_rsp(0, rc1);
        if (rc1 >= 0) check_rsp(0, acc1, rc1, 24'h411200, 8'hF0);
        @(negedge clk);
        wait_ready(0, acc2);
        chk("b2b_gap", 32'(acc2 - rc1), 32'd2);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        wait_rsp(0, rc2);
        if (rc2 >= 0) check_rsp(0, acc2, rc2, 24'h4A34A5, 8'h00);

        // Reset asserted in the middle of a read
        rbyte[0] = 8'hF0;
        @(negedge clk);
        drive(0, 1'b1, 3'd0, 8'h12, 8'h00);
        cmd_valid[0] = 1'b1;
        wait_ready(0, acc1);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        for (int i = 0; i < 500 && mon_bits[0] != 10; i++) @(negedge clk);
        chk("abort_at_bit10", 32'(mon_bits[0]), 32'd10);
        r0 = mon_rsp[0];
        rstn[0] = 1'b0;
        #1;
        chk("abort_csn",   32'(csn[0]),       32'd1);
        chk("abort_sclk",  32'(sclk[0]),      32'd0);
        chk("abort_ready", 32'(cmd_ready[0]), 32'd0);
        repeat (4) @(negedge clk);
        rstn[0] = 1'b1;
        for (int i = 0; i < 200 && !cmd_ready[0]; i++) @(negedge clk);
        chk("abort_no_rsp", 32'(mon_rsp[0]), 32'(r0));
        run_cmd(0, 1'b1, 3'd0, 8'h12, 8'h00, 8'hF0);

        // Slower divider, two trailing pulses
        run_cmd(1, 1'b1, 3'd3, 8'h05, 8'h00, 8'h0F);
        run_cmd(1, 1'b0, 3'd7, 8'hFF, 8'hC3, 8'h00);

        // Randomized commands on both instances
        for (int i = 0; i < 8; i++) begin
            rw = 1'($urandom);
            rb = 8'($urandom);
            run_cmd(i % 2, rw, 3'($urandom), 8'($urandom), 8'($urandom), rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
